morse_receiver: RTL
===================

Name: morse_receiver

Overview:
Serial Morse receiver for the SW-selected letter set S..Z: the receive-side counterpart of the letter-to-Morse LUT/shift-register transmitter.
- Samples a one-bit Morse line once per Morse unit (tick strobe from the shared clock divider).
- Measures mark and space run lengths and classifies marks as dot or dash.
- Detects the end of a letter and decodes the element sequence back to the 3-bit letter code used by the transmit LUT.
- Drives LEDR/HEX display logic in the top level.

Parameters:
RUN_W, 4, width of the mark/space run counters (saturating)
MAX_ELEMS, 4, maximum dots+dashes per letter

Ports:
clk  input  1  system clock (CLOCK_50 in top level)
reset_n  input  1  asynchronous active-low reset
tick  input  1  one-clk strobe, one per Morse unit; never asserted on two consecutive clks
din  input  1  serial Morse line, 1 = mark; sampled only on clks with tick=1
letter_out  output  3  last successfully decoded letter code
letter_valid  output  1  one-clk pulse: letter_out just updated
error  output  1  one-clk pulse: malformed letter received and discarded
busy  output  1  high while a letter is in progress (state != IDLE)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; counters, element buffer and err flag cleared; letter_out=3'b000; letter_valid=0; error=0. Reset mid-letter discards the partial letter with no pulse.
- Clks without tick: no state change except letter_valid/error returning to 0.
- Element encoding: dot=0, dash=1, shifted in at LSB. elem_cnt holds 0..MAX_ELEMS.
- IDLE:
  - tick, din=0: stay.
  - tick, din=1: go to MARK; mark_cnt=1; elem buffer, elem_cnt and err cleared.
- MARK:
  - tick, din=1: mark_cnt++ (saturate at 2^RUN_W-1).
  - tick, din=0: classify the mark. mark_cnt==1 appends dot; mark_cnt==3 appends dash; any other length sets err and appends nothing. If elem_cnt is already MAX_ELEMS, set err (no append). Then go to SPACE with space_cnt=1.
- SPACE:
  - tick, din=1: if space_cnt==1 (intra-letter gap), go to MARK with mark_cnt=1. If space_cnt==2, set err, then go to MARK with mark_cnt=1.
  - tick, din=0: space_cnt++. When it reaches 3 (letter gap), end the letter and go to IDLE.
- End of letter: decode on the same clk edge that moves SPACE to IDLE; outputs are registered and appear the following cycle.
  - If err=0 and (elem_cnt, pattern) matches the table: letter_valid=1 for one clk, letter_out loaded.
  - Otherwise: error=1 for one clk, letter_out unchanged.
  - letter_valid and error are never high together.
- Decode table (elem_cnt, pattern oldest->newest → code):
  - S 3,000 → 000
  - T 1,1 → 001
  - U 3,001 → 010
  - V 4,0001 → 011
  - W 3,011 → 100
  - X 4,1001 → 101
  - Y 4,1011 → 110
  - Z 4,1100 → 111
- Unbounded mark (din stuck high): stays in MARK, no output. Zeros in IDLE are ignored, so the transmitter's trailing zero fill is harmless.
- Latency: outputs pulse 1 clk after the tick that samples the 3rd consecutive space.

Decomposition:
- Shared package morse_pkg holds:
  - DOT_UNITS=1, DASH_UNITS=3, LETTER_GAP_UNITS=3
  - element encodings DOT=1'b0, DASH=1'b1
  - letter codes LTR_S..LTR_Z = 3'b000..3'b111
  - state enum {IDLE, MARK, SPACE}
- One combinational sub-module, morse_pattern_lut: inputs elem_cnt and pattern; outputs letter code and hit. It is the inverse of the transmit LUT and is reusable in transmit/receive loopback benches.

Test Plan:
- Reset, tick every 4 clks, din=10101000 (S) → one letter_valid pulse, letter_out=000, error never high, busy low afterwards.
- din=1110111010100000 (Z, full transmitter frame) → letter_valid once, letter_out=111; trailing zeros produce no further pulses.
- Back-to-back din=111000 then 1011101110000 (T then W) → two letter_valid pulses, letter_out=001 then 100.
- Malformed mark din=110 000 after a prior valid W → error pulse, no letter_valid, letter_out stays 100. Separately, din=1 00 1 000 (2-unit gap) → error pulse.
- Overflow din=1010101010 000 (5 dots) → error pulse, no letter_valid.
- Assert reset_n=0 after 6 ticks of Y, release, send V (1010101110000) → busy low during reset, no pulse for Y, then letter_valid with letter_out=011. Toggling din with tick=0 causes no state change.

Source files
------------

// File: rtl/morse_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// morse_pkg
// Shared constants and types for the Morse transmit/receive path covering the
// letter set S..Z.
//   - unit lengths of dot, dash and inter-letter gap (in Morse units / ticks)
//   - element encodings as shifted into the element buffer
//   - 3-bit letter codes used by the transmit LUT
//   - receiver state enum
// -----------------------------------------------------------------------------
package morse_pkg;

    // Run lengths, in Morse units
    localparam int DOT_UNITS        = 1;
    localparam int DASH_UNITS       = 3;
    localparam int LETTER_GAP_UNITS = 3;
    // A one-unit space separates elements inside a letter
    localparam int ELEM_GAP_UNITS   = 1;

    // Element encodings, shifted in at the LSB (newest element at bit 0)
    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    // Letter codes shared with the transmit LUT
    localparam logic [2:0] LTR_S = 3'b000;
    localparam logic [2:0] LTR_T = 3'b001;
    localparam logic [2:0] LTR_U = 3'b010;
    localparam logic [2:0] LTR_V = 3'b011;
    localparam logic [2:0] LTR_W = 3'b100;
    localparam logic [2:0] LTR_X = 3'b101;
    localparam logic [2:0] LTR_Y = 3'b110;
    localparam logic [2:0] LTR_Z = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

endpackage

// File: rtl/morse_pattern_lut.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// morse_pattern_lut
// Combinational inverse of the transmit letter LUT: maps a received element
// sequence back to its 3-bit letter code.
//   i_elem_cnt : number of valid elements in i_pattern (0..MAX_ELEMS)
//   i_pattern  : elements, oldest in the highest used bit, newest at bit 0;
//                unused upper bits must be zero
//   o_letter   : decoded letter code (LTR_S when no hit)
//   o_hit      : 1 when (i_elem_cnt, i_pattern) is one of S..Z
// MAX_ELEMS must be at least 4 (longest letters in the set have 4 elements).
// -----------------------------------------------------------------------------
module morse_pattern_lut
    import morse_pkg::*;
#(
    parameter int MAX_ELEMS = 4,
    parameter int CNT_W     = $clog2(MAX_ELEMS + 1)
) (
    input  logic [CNT_W-1:0]     i_elem_cnt,
    input  logic [MAX_ELEMS-1:0] i_pattern,
    output logic [2:0]           o_letter,
    output logic                 o_hit
);

    // Both count and full pattern must match; the zeroed upper bits make
    // e.g. S (3,000) distinct from a 4-element 0000.
    function automatic logic is_pat(input logic [CNT_W-1:0]     cnt,
                                    input logic [MAX_ELEMS-1:0] pat,
                                    input int                   n,
                                    input logic [3:0]           p);
        return (cnt == CNT_W'(n)) && (pat == MAX_ELEMS'(p));
    endfunction

    always_comb begin
        o_hit    = 1'b1;
        o_letter = LTR_S;
        if      (is_pat(i_elem_cnt, i_pattern, 3, 4'b0000)) o_letter = LTR_S;
        else if (is_pat(i_elem_cnt, i_pattern, 1, 4'b0001)) o_letter = LTR_T;
        else if (is_pat(i_elem_cnt, i_pattern, 3, 4'b0001)) o_letter = LTR_U;
        else if (is_pat(i_elem_cnt, i_pattern, 4, 4'b0001)) o_letter = LTR_V;
        else if (is_pat(i_elem_cnt, i_pattern, 3, 4'b0011)) o_letter = LTR_W;
        else if (is_pat(i_elem_cnt, i_pattern, 4, 4'b1001)) o_letter = LTR_X;
        else if (is_pat(i_elem_cnt, i_pattern, 4, 4'b1011)) o_letter = LTR_Y;
        else if (is_pat(i_elem_cnt, i_pattern, 4, 4'b1100)) o_letter = LTR_Z;
        else                                                  o_hit    = 1'b0;
    end

endmodule

// File: rtl/morse_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// morse_receiver
// Serial Morse receiver for letters S..Z. Samples din once per Morse unit
// (tick), measures mark/space run lengths, classifies marks as dot/dash and,
// on a 3-unit letter gap, decodes the element sequence to a 3-bit letter code.
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   tick         : one-clk strobe per Morse unit
//   din          : Morse line, 1 = mark, sampled only when tick=1
//   letter_out   : last successfully decoded letter code
//   letter_valid : one-clk pulse, letter_out just updated
//   error        : one-clk pulse, malformed letter discarded
//   busy         : a letter is in progress
// -----------------------------------------------------------------------------
module morse_receiver
    import morse_pkg::*;
#(
    parameter int RUN_W     = 4,
    parameter int MAX_ELEMS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       din,
    output logic [2:0] letter_out,
    output logic       letter_valid,
    output logic       error,
    output logic       busy
);

    localparam int               CNT_W   = $clog2(MAX_ELEMS + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    state_t                 r_state;
    logic [RUN_W-1:0]       r_mark_cnt;
    logic [RUN_W-1:0]       r_space_cnt;
    logic [MAX_ELEMS-1:0]   r_elems;
    logic [CNT_W-1:0]       r_elem_cnt;
    logic                   r_err;
    logic [2:0]             r_letter_out;
    logic                   r_letter_valid;
    logic                   r_error;

    logic                   w_is_dot;
    logic                   w_is_dash;
    logic                   w_elems_full;
    logic                   w_gap_done;
    logic [2:0]             w_letter;
    logic                   w_hit;

    assign w_is_dot     = (r_mark_cnt == RUN_W'(DOT_UNITS));
    assign w_is_dash    = (r_mark_cnt == RUN_W'(DASH_UNITS));
    assign w_elems_full = (r_elem_cnt == CNT_W'(MAX_ELEMS));
    // This tick's space is the one that completes the letter gap
    assign w_gap_done   = (r_space_cnt == RUN_W'(LETTER_GAP_UNITS - 1));

    // Decode sees the buffer as it stands while in SPACE; nothing appends
    // there, so it is already final on the gap-completing tick.
    morse_pattern_lut #(
        .MAX_ELEMS (MAX_ELEMS),
        .CNT_W     (CNT_W)
    ) u_lut (
        .i_elem_cnt (r_elem_cnt),
        .i_pattern  (r_elems),
        .o_letter   (w_letter),
        .o_hit      (w_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_mark_cnt     <= '0;
            r_space_cnt    <= '0;
            r_elems        <= '0;
            r_elem_cnt     <= '0;
            r_err          <= 1'b0;
            r_letter_out   <= LTR_S;
            r_letter_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_letter_valid <= 1'b0;
            r_error        <= 1'b0;
            if (tick) begin
                case (r_state)
                    IDLE: begin
                        // Leading/trailing zero fill is ignored here
                        if (din) begin
                            r_state    <= MARK;
                            r_mark_cnt <= RUN_W'(1);
                            r_elems    <= '0;
                            r_elem_cnt <= '0;
                            r_err      <= 1'b0;
                        end
                    end
                    MARK: begin
                        if (din) begin
                            if (r_mark_cnt != RUN_MAX)
                                r_mark_cnt <= r_mark_cnt + 1'b1;
                        end else begin
                            // Bad mark length or buffer overflow poisons the
                            // letter; it is still framed by its gap.
                            if ((w_is_dot || w_is_dash) && !w_elems_full) begin
                                r_elems    <= {r_elems[MAX_ELEMS-2:0],
                                               (w_is_dash ? DASH : DOT)};
                                r_elem_cnt <= r_elem_cnt + 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                            r_state     <= SPACE;
                            r_space_cnt <= RUN_W'(1);
                        end
                    end
                    SPACE: begin
                        if (din) begin
                            // Only a one-unit gap is legal between elements;
                            // a two-unit gap is neither element nor letter gap.
                            if (r_space_cnt != RUN_W'(ELEM_GAP_UNITS))
                                r_err <= 1'b1;
                            r_state    <= MARK;
                            r_mark_cnt <= RUN_W'(1);
                        end else begin
                            r_space_cnt <= r_space_cnt + 1'b1;
                            if (w_gap_done) begin
                                r_state <= IDLE;
                                if (!r_err && w_hit) begin
                                    r_letter_valid <= 1'b1;
                                    r_letter_out   <= w_letter;
                                end else begin
                                    r_error <= 1'b1;
                                end
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign letter_out   = r_letter_out;
    assign letter_valid = r_letter_valid;
    assign error        = r_error;
    assign busy         = (r_state != IDLE);

endmodule
